// File: rtl/audio_pkg.sv
// Shared audio block/sample types for the audio output path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

  localparam int INW        = 512;
  localparam int DATAW      = 32;
  localparam int NUMSAMPLES = INW / DATAW;

  typedef logic [DATAW-1:0]           sample_t;
  typedef sample_t [NUMSAMPLES-1:0]   block_t;

endpackage

// File: rtl/audio_block_fifo.sv
// Block FIFO: DEPTH entries of one full audio block each, head visible combinationally.
// Latency: push in cycle N is visible at the head/empty flag in N+1.
// Backpressure: full_o blocks further pushes; push while full and pop while empty are ignored.
module audio_block_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic [INW-1:0] wdata_i,
  input  logic           pop_i,
  output logic [INW-1:0] head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Block storage is data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy next-state; simultaneous push/pop keeps count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/audio_out_serializer.sv
// Buffers 512-bit audio blocks and plays one 32-bit sample per sample-rate tick; optional underrun counter via AUDIO_SER_UNDERRUN_CNT_EN.
// Latency: pushed block can emit its first sample the next cycle if a tick is pending; tx_done/underrun one cycle after their cause.
// Backpressure: in_ready drops while the FIFO is full; a held sample waits on sample_ready without accumulating extra ticks.
module audio_out_serializer
  import audio_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int TICK_DIV = 2268
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             audio_valid,
  input  logic [INW-1:0]   audio_in,
  output logic             in_ready,
  output logic             tx_done,
  output logic [DATAW-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             underrun
`ifdef AUDIO_SER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_count
`endif
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUMSAMPLES);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic          tx_done_q, underrun_q;

  logic          tick, push, hs, last, pop;
  logic          fifo_full, fifo_empty;
  block_t        head;

  assign tick = (tcnt_q == TW'(TICK_DIV - 1));
  assign push = audio_valid && in_ready;
  assign hs   = sample_valid && sample_ready;
  assign last = (idx_q == IW'(NUMSAMPLES - 1));
  assign pop  = hs && last;

  audio_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (audio_in),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready     = !fifo_full;
  assign sample_valid = pending_q && !fifo_empty;
  assign sample_out   = sample_valid ? head[idx_q] : '0;
  assign tx_done      = tx_done_q;
  assign underrun     = underrun_q;

  // Tick counter wrap, pending flag (a tick wins over a same-cycle handshake) and sample index
  always_comb begin
    tcnt_d    = tick ? '0 : tcnt_q + TW'(1);
    pending_d = pending_q;
    idx_d     = idx_q;
    if (hs) begin
      pending_d = 1'b0;
      idx_d     = last ? '0 : idx_q + IW'(1);
    end
    if (tick) begin
      pending_d = 1'b1;
    end
  end

  // Control state and registered one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q     <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      tx_done_q  <= pop;
      underrun_q <= tick && fifo_empty;
    end
  end

`ifdef AUDIO_SER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count, stepped alongside each underrun pulse
  always_comb begin
    ucnt_d = ucnt_q;
    if (tick && fifo_empty && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_audio_out_serializer.sv
// Self-checking bench for audio_out_serializer with DEPTH=2, TICK_DIV=4.
// Latency: n/a.
// Backpressure: exercised through sample_ready stalls and a full FIFO.
module tb_audio_out_serializer;
  import audio_pkg::*;

  localparam int DEPTH    = 2;
  localparam int TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             audio_valid = 1'b0;
  logic [INW-1:0]   audio_in = '0;
  logic             sample_ready = 1'b0;
  logic             in_ready, tx_done, sample_valid, underrun;
  logic [DATAW-1:0] sample_out;
`ifdef AUDIO_SER_UNDERRUN_CNT_EN
  logic [15:0]      underrun_count;
`endif

  audio_out_serializer #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .audio_valid  (audio_valid),
    .audio_in     (audio_in),
    .in_ready     (in_ready),
    .tx_done      (tx_done),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun     (underrun)
`ifdef AUDIO_SER_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_total = 0, txd_total = 0, und_total = 0, valid_cycles = 0;
  int prev_hs_cyc = -1, first_hs_cyc = 0, last_hs_cyc = 0, txd_cyc = 0;
  int gap_min = 1000, gap_max = 0, blk_hs = 0;
  logic [31:0] first_smp = '0, last_smp = '0;
  logic [31:0] sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic reset_stats();
    prev_hs_cyc = -1;
    gap_min     = 1000;
    gap_max     = 0;
    blk_hs      = 0;
  endtask

  // One clock: observe at the negedge (handshake that the next edge takes), return 1 after the posedge
  task automatic step();
    logic [31:0] e;
    int gap;
    @(negedge clk);
    if (sample_valid) valid_cycles++;
    if (sample_valid && sample_ready) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_sample");
      end else begin
        e = sb_q.pop_front();
        check("sample", sample_out, e);
      end
      if (blk_hs == 0) begin
        first_smp    = sample_out;
        first_hs_cyc = cyc;
      end
      last_smp = sample_out;
      if (prev_hs_cyc >= 0) begin
        gap = cyc - prev_hs_cyc;
        if (gap < gap_min) gap_min = gap;
        if (gap > gap_max) gap_max = gap;
      end
      prev_hs_cyc = cyc;
      last_hs_cyc = cyc;
      blk_hs++;
      hs_total++;
    end
    if (tx_done) begin
      txd_total++;
      txd_cyc = cyc;
    end
    if (underrun) und_total++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_block(input logic [31:0] base, input logic [31:0] stride);
    for (int i = 0; i < NUMSAMPLES; i++) begin
      audio_in[i*DATAW +: DATAW] = base + stride * 32'(i);
    end
  endtask

  task automatic enqueue_block(input logic [31:0] base, input logic [31:0] stride);
    for (int i = 0; i < NUMSAMPLES; i++) begin
      sb_q.push_back(base + stride * 32'(i));
    end
  endtask

  task automatic push_block(input logic [31:0] base, input logic [31:0] stride);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) fail_now("push_wait_in_ready");
    load_block(base, stride);
    enqueue_block(base, stride);
    audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (hs_total < target && n < budget) begin
      step();
      n++;
    end
    if (hs_total < target) fail_now(name);
  endtask

  task automatic wait_phase(input int ph);
    for (int n = 0; n < TICK_DIV; n++) begin
      if ((cyc % TICK_DIV) == ph) break;
      step();
    end
  endtask

  initial begin
    int t0, h0, u0, c1, vcount, bad, n;

    tbl[0] = '{32'hA000_0000, 32'h0000_0001, 32'hA000_0000, 32'hA000_000F};
    tbl[1] = '{32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[2] = '{32'hFFFF_FFF8, 32'h0000_0001, 32'hFFFF_FFF8, 32'h0000_0007};
    tbl[3] = '{32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 32'h8F00_0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_sample_out", sample_out, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
`ifdef AUDIO_SER_UNDERRUN_CNT_EN
    check("rst_underrun_count", 32'(underrun_count), 32'd0);
`endif
    rst_n = 1'b1;
    cyc   = 0;
    reset_stats();

    // Underruns: three ticks with an empty FIFO
    sample_ready = 1'b1;
    u0 = und_total;
    repeat (14) step();
    check("underrun_pulses", 32'(und_total - u0), 32'd3);
    check("underrun_no_valid", 32'(valid_cycles), 32'd0);
`ifdef AUDIO_SER_UNDERRUN_CNT_EN
    check("underrun_count", 32'(underrun_count), 32'd3);
`endif

    // Table-driven blocks played at full rate, each pushed on a tick cycle
    for (int v = 0; v < 4; v++) begin
      wait_phase(TICK_DIV - 1);
      reset_stats();
      t0 = txd_total;
      h0 = hs_total;
      push_block(tbl[v].base, tbl[v].stride);
      c1 = cyc - 1;
      wait_hs(h0 + NUMSAMPLES, 200, "table_drain");
      repeat (2) step();
      check("tbl_first", first_smp, tbl[v].exp_first);
      check("tbl_last", last_smp, tbl[v].exp_last);
      check("tbl_first_latency", 32'(first_hs_cyc - c1), 32'd1);
      check("tbl_gap_min", 32'(gap_min), 32'(TICK_DIV));
      check("tbl_gap_max", 32'(gap_max), 32'(TICK_DIV));
      check("tbl_tx_done_count", 32'(txd_total - t0), 32'd1);
      check("tbl_tx_done_time", 32'(txd_cyc - last_hs_cyc), 32'd1);
    end

    // FIFO full: two blocks fill it, a held third waits for the first pop
    t0 = txd_total;
    h0 = hs_total;
    push_block(32'hB000_0000, 32'd1);
    push_block(32'hC000_0000, 32'd1);
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    load_block(32'hD000_0000, 32'd1);
    audio_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) fail_now("full_wait_in_ready");
    check("full_reopen_with_tx_done", 32'(tx_done), 32'd1);
    check("full_reopen_one_block_done", 32'(txd_total - t0), 32'd0);
    enqueue_block(32'hD000_0000, 32'd1);
    step();
    audio_valid = 1'b0;
    wait_hs(h0 + 3 * NUMSAMPLES, 400, "full_drain");
    repeat (2) step();
    check("full_tx_done_count", 32'(txd_total - t0), 32'd3);
    check("full_sb_empty", 32'(sb_q.size()), 32'd0);

    // Push coincident with the final-sample pop of the only queued block
    reset_stats();
    h0 = hs_total;
    push_block(32'h1000_0000, 32'd1);
    n = 0;
    while (!(sample_valid && blk_hs == NUMSAMPLES - 1) && n < 200) begin
      step();
      n++;
    end
    if (!(sample_valid && blk_hs == NUMSAMPLES - 1)) fail_now("coinc_wait_last");
    load_block(32'h2000_0000, 32'd1);
    enqueue_block(32'h2000_0000, 32'd1);
    audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    check("coinc_in_ready_count1", 32'(in_ready), 32'd1);
    push_block(32'h3000_0000, 32'd1);
    check("coinc_in_ready_count2", 32'(in_ready), 32'd0);
    wait_hs(h0 + 3 * NUMSAMPLES, 400, "coinc_drain");
    check("coinc_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure: hold sample_ready low across three ticks
    sample_ready = 1'b0;
    h0 = hs_total;
    push_block(32'hE000_0000, 32'd1);
    vcount = 0;
    bad    = 0;
    repeat (14) begin
      step();
      if (sample_valid) begin
        vcount++;
        if (sample_out !== 32'hE000_0000) bad++;
      end
    end
    check("bp_valid_held", 32'(sample_valid), 32'd1);
    check("bp_out_word0", sample_out, 32'hE000_0000);
    check("bp_out_stable_errors", 32'(bad), 32'd0);
    check("bp_no_take", 32'(hs_total - h0), 32'd0);
    wait_phase(0);
    sample_ready = 1'b1;
    step();
    c1 = last_hs_cyc;
    check("bp_one_taken", 32'(hs_total - h0), 32'd1);
    check("bp_valid_dropped", 32'(sample_valid), 32'd0);
    wait_hs(h0 + 2, 20, "bp_second");
    check("bp_next_on_tick", 32'(last_hs_cyc - c1), 32'(TICK_DIV));

    // Tick in the handshake cycle keeps the next sample pending
    sample_ready = 1'b0;
    n = 0;
    while (!(sample_valid && (cyc % TICK_DIV) == TICK_DIV - 1) && n < 40) begin
      step();
      n++;
    end
    if (!(sample_valid && (cyc % TICK_DIV) == TICK_DIV - 1)) fail_now("tick_hs_wait");
    sample_ready = 1'b1;
    h0 = hs_total;
    step();
    check("tick_hs_pending_kept", 32'(sample_valid), 32'd1);
    step();
    check("tick_hs_two_taken", 32'(hs_total - h0), 32'd2);
    wait_hs(hs_total + sb_q.size(), 200, "bp_drain");
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a block
    h0 = hs_total;
    push_block(32'hF000_0000, 32'd1);
    wait_hs(h0 + 5, 60, "mid_rst_five");
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sample_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_sample_out", sample_out, 32'd0);
    check("mid_rst_tx_done", 32'(tx_done), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
`ifdef AUDIO_SER_UNDERRUN_CNT_EN
    check("mid_rst_underrun_count", 32'(underrun_count), 32'd0);
`endif
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    reset_stats();
    t0 = txd_total;
    h0 = hs_total;
    repeat (20) step();
    check("post_rst_no_tx_done", 32'(txd_total - t0), 32'd0);
    check("post_rst_no_samples", 32'(hs_total - h0), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid_low", 32'(sample_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
